vec_alu_multilane: RTL

- Multi-lane, beat-serial vector integer ALU; successor to the single-lane vec_alu; sits between the vector register file read ports and the write-back path.
- Processes a VLEN-bit operand pair in beats of NL lanes × LW bits per cycle.
- SEW smaller than LW is packed SIMD inside a lane; SEW larger than a beat chains carries across beats.
- Adds arithmetic ops, vl tail handling, a start/busy/done handshake and illegal-config reporting.

---
 rtl/vec_alu_pkg.sv | 64 ++++++
 rtl/vec_alu_lane.sv | 48 ++++
 rtl/vec_alu_multilane.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vec_alu_multilane vector ALU: funct6 codes, SEW
// encoding, FSM states, lane operation codes and element-boundary helpers.
package vec_alu_pkg;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VRSUB = 6'b000011;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;
  localparam logic [5:0] OP_VMV   = 6'b010111;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    LOP_ADD  = 3'd0,
    LOP_SUB  = 3'd1,
    LOP_AND  = 3'd2,
    LOP_OR   = 3'd3,
    LOP_XOR  = 3'd4,
    LOP_MOVA = 3'd5
  } lane_op_e;

  // Upper bound on beat width; wide enough for 64-bit lanes times 8 lanes.
  localparam int MAX_BEAT = 512;

  // Bit j is set when bit (base + j) of the register is the LSB of an element.
  function automatic logic [MAX_BEAT-1:0] elem_bound_mask(input logic [1:0] vsew,
                                                          input int beat_bits,
                                                          input int base);
    logic [MAX_BEAT-1:0] m;
    int sew_bits;
    m = '0;
    sew_bits = 32'sd8 << vsew;
    for (int j = 0; j < MAX_BEAT; j++) begin
      if (j < beat_bits) begin
        m[j] = (((base + j) & (sew_bits - 32'sd1)) == 32'sd0);
      end else begin
        m[j] = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_VADD, OP_VSUB, OP_VRSUB, OP_VAND, OP_VOR, OP_VXOR, OP_VMV: ok = 1'b1;
      default:                                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One LW-bit SIMD lane: ripple add/sub with per-bit element-start kill, plus
// bitwise logic and pass-through of operand a.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int LW = 16
) (
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  input  lane_op_e      op,
  input  logic          cin,
  input  logic [LW-1:0] kill,
  output logic [LW-1:0] res,
  output logic          cout
);

  logic [LW:0]   c_s;
  logic [LW-1:0] y_s;
  logic [LW-1:0] sum_s;
  logic          seed_s;
  logic          ci_s;

  // Carry chain restarts at element starts with the subtract seed (a + ~b + 1).
  always_comb begin
    seed_s = (op == LOP_SUB);
    y_s    = (op == LOP_SUB) ? ~b : b;
    c_s    = '0;
    sum_s  = '0;
    ci_s   = 1'b0;
    c_s[0] = cin;
    for (int j = 0; j < LW; j++) begin
      ci_s       = kill[j] ? seed_s : c_s[j];
      sum_s[j]   = a[j] ^ y_s[j] ^ ci_s;
      c_s[j+1]   = (a[j] & y_s[j]) | (ci_s & (a[j] ^ y_s[j]));
    end
    case (op)
      LOP_ADD, LOP_SUB: res = sum_s;
      LOP_AND:          res = a & b;
      LOP_OR:           res = a | b;
      LOP_XOR:          res = a ^ b;
      LOP_MOVA:         res = a;
      default:          res = a;
    endcase
  end

  assign cout = c_s[LW];

endmodule

// File: rtl/vec_alu_multilane.sv
// vec_alu_multilane: beat-serial vector integer ALU, NL lanes x LW bits per beat.
// Build macro VEC_ALU_MASK_EN adds the v0 mask port (mask-undisturbed elements).
module vec_alu_multilane
  import vec_alu_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            opcode,
  input  logic [2:0]            vsew,
  input  logic [$clog2(VLEN):0] vl,
  input  logic [VLEN-1:0]       vs1,
  input  logic [VLEN-1:0]       vs2,
  input  logic [VLEN-1:0]       vd_old,
`ifdef VEC_ALU_MASK_EN
  input  logic [VLEN-1:0]       v0,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [VLEN-1:0]       vd
);

  localparam int LW     = 1 << LANE_WIDTH;
  localparam int NL     = 1 << NB_LANES;
  localparam int BEAT   = LW * NL;
  localparam int NBEATS = VLEN / BEAT;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IW     = $clog2(VLEN);
  localparam int VLW    = $clog2(VLEN) + 1;

  state_e                       state_r, state_nxt_s;
  logic [5:0]                   op_r;
  logic [1:0]                   sew_r;
  logic [VLW-1:0]               vl_r;
  logic [NBEATS-1:0][BEAT-1:0]  vs1_r, vs2_r, vd_old_r, vd_r;
`ifdef VEC_ALU_MASK_EN
  logic [VLEN-1:0]              v0_r;
`endif
  logic [BW-1:0]                beat_r;
  logic                         carry_r;
  logic                         done_r;
  logic                         illegal_r;

  logic                         accept_s, legal_s, last_beat_s;
  lane_op_e                     lop_s;
  logic [BEAT-1:0]              a_s, b_s, kill_s, res_s, merged_s, old_s;
  logic [NL:0]                  lcarry_s;
  int                           beat_off_s;
  logic [31:0]                  idx_s;
  logic                         act_s;

  assign accept_s    = start && (state_r == IDLE);
  assign legal_s     = op_supported(opcode) && (vsew[2] == 1'b0);
  assign last_beat_s = (beat_r == BW'(NBEATS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next state: illegal requests never enter RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && legal_s) state_nxt_s = RUN;
        else                     state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_beat_s) state_nxt_s = IDLE;
        else             state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Beat operand steering and element-boundary kill mask
  always_comb begin
    beat_off_s = int'(beat_r) * BEAT;
    kill_s     = BEAT'(elem_bound_mask(sew_r, BEAT, beat_off_s));
    old_s      = vd_old_r[beat_r];
    lop_s      = LOP_MOVA;
    a_s        = vs1_r[beat_r];
    b_s        = vs2_r[beat_r];
    case (op_r)
      OP_VADD:  begin lop_s = LOP_ADD;  a_s = vs2_r[beat_r]; b_s = vs1_r[beat_r]; end
      OP_VSUB:  begin lop_s = LOP_SUB;  a_s = vs2_r[beat_r]; b_s = vs1_r[beat_r]; end
      OP_VRSUB: begin lop_s = LOP_SUB;  a_s = vs1_r[beat_r]; b_s = vs2_r[beat_r]; end
      OP_VAND:  begin lop_s = LOP_AND;  a_s = vs2_r[beat_r]; b_s = vs1_r[beat_r]; end
      OP_VOR:   begin lop_s = LOP_OR;   a_s = vs2_r[beat_r]; b_s = vs1_r[beat_r]; end
      OP_VXOR:  begin lop_s = LOP_XOR;  a_s = vs2_r[beat_r]; b_s = vs1_r[beat_r]; end
      OP_VMV:   begin lop_s = LOP_MOVA; a_s = vs1_r[beat_r]; b_s = vs2_r[beat_r]; end
      default:  begin lop_s = LOP_MOVA; a_s = vs1_r[beat_r]; b_s = vs2_r[beat_r]; end
    endcase
  end

  assign lcarry_s[0] = carry_r;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    vec_alu_lane #(.LW(LW)) u_lane (
      .a    (a_s[i*LW +: LW]),
      .b    (b_s[i*LW +: LW]),
      .op   (lop_s),
      .cin  (lcarry_s[i]),
      .kill (kill_s[i*LW +: LW]),
      .res  (res_s[i*LW +: LW]),
      .cout (lcarry_s[i+1])
    );
  end

  // Tail/mask merge; element index is always below VLEN/SEW, so idx < vl clamps vl
  always_comb begin
    merged_s = old_s;
    idx_s    = 32'd0;
    act_s    = 1'b0;
    for (int j = 0; j < BEAT; j++) begin
      idx_s = (32'(beat_off_s) + 32'(j)) >> (32'd3 + 32'(sew_r));
`ifdef VEC_ALU_MASK_EN
      act_s = (idx_s < 32'(vl_r)) && v0_r[idx_s[IW-1:0]];
`else
      act_s = (idx_s < 32'(vl_r)) && (idx_s[IW-1:0] == idx_s[IW-1:0]);
`endif
      merged_s[j] = act_s ? res_s[j] : old_s[j];
    end
  end

  // Operand capture, beat write-back, carry and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= 6'd0;
      sew_r     <= 2'd0;
      vl_r      <= '0;
      vs1_r     <= '0;
      vs2_r     <= '0;
      vd_old_r  <= '0;
`ifdef VEC_ALU_MASK_EN
      v0_r      <= '0;
`endif
      vd_r      <= '0;
      beat_r    <= '0;
      carry_r   <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      if (accept_s) begin
        op_r     <= opcode;
        sew_r    <= vsew[1:0];
        vl_r     <= vl;
        vs1_r    <= vs1;
        vs2_r    <= vs2;
        vd_old_r <= vd_old;
`ifdef VEC_ALU_MASK_EN
        v0_r     <= v0;
`endif
        beat_r   <= '0;
        carry_r  <= 1'b0;
        if (!legal_s) begin
          done_r    <= 1'b1;
          illegal_r <= 1'b1;
          vd_r      <= vd_old;
        end
      end else if (state_r == RUN) begin
        vd_r[beat_r] <= merged_s;
        carry_r      <= lcarry_s[NL];
        beat_r       <= beat_r + BW'(1);
        if (last_beat_s) done_r <= 1'b1;
      end
    end
  end

  assign busy    = (state_r == RUN);
  assign done    = done_r;
  assign illegal = illegal_r;
  assign vd      = vd_r;

endmodule
